// File: rtl/bsg_dmc_ui_master_pkg.sv
// Shared types for the DMC user-interface client slice.
//   app_cmd_e                  : command encoding driven on app_cmd_o
//   bsg_dmc_ui_master_state_e  : sequencer states of bsg_dmc_ui_master
package bsg_dmc_ui_master_pkg;

  typedef enum logic [2:0] {
    APP_CMD_WR = 3'b000,
    APP_CMD_RD = 3'b001
  } app_cmd_e;

  typedef enum logic [2:0] {
    UI_M_IDLE  = 3'd0,
    UI_M_WDATA = 3'd1,
    UI_M_CMD   = 3'd2,
    UI_M_RWAIT = 3'd3,
    UI_M_RESP  = 3'd4
  } bsg_dmc_ui_master_state_e;

endpackage

// File: rtl/bsg_dmc_ui_master_if.sv
// DMC app_* bus bundle.
//   master modport : client side (drives command, write data; receives read data)
//   slave modport  : controller side
// Signal names keep the app_* port naming of the controller so both sides
// read identically.
interface bsg_dmc_ui_master_if
  import bsg_dmc_ui_master_pkg::*;
#(
  parameter int ui_addr_width_p = 28,
  parameter int ui_data_width_p = 32
) ();

  localparam int ui_mask_width_lp = ui_data_width_p >> 3;

  logic [ui_addr_width_p-1:0]  app_addr_o;
  app_cmd_e                    app_cmd_o;
  logic                        app_en_o;
  logic                        app_rdy_i;
  logic                        app_wdf_wren_o;
  logic [ui_data_width_p-1:0]  app_wdf_data_o;
  logic [ui_mask_width_lp-1:0] app_wdf_mask_o;
  logic                        app_wdf_end_o;
  logic                        app_wdf_rdy_i;
  logic                        app_rd_data_valid_i;
  logic [ui_data_width_p-1:0]  app_rd_data_i;
  logic                        app_rd_data_end_i;

  modport master (
    output app_addr_o, app_cmd_o, app_en_o,
    output app_wdf_wren_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o,
    input  app_rdy_i, app_wdf_rdy_i,
    input  app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i
  );

  modport slave (
    input  app_addr_o, app_cmd_o, app_en_o,
    input  app_wdf_wren_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o,
    output app_rdy_i, app_wdf_rdy_i,
    output app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i
  );

endinterface

// File: rtl/bsg_dmc_ui_rd_collect.sv
// Read-beat deserializer for bsg_dmc_ui_master.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   clear_i          : restart the beat counter at slot 0
//   active_i         : beats are being awaited; beats outside this window are ignored
//   v_i/data_i/end_i : returned read beat, its data and the controller's end flag
//   line_o           : assembled line, beat 0 in the LSBs
//   last_o           : the beat arriving this cycle fills the final slot
//   end_err_o        : end flag of the arriving beat disagrees with its slot position
module bsg_dmc_ui_rd_collect #(
  parameter int ui_data_width_p    = 32,
  parameter int burst_data_width_p = 128
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          clear_i,
  input  logic                          active_i,
  input  logic                          v_i,
  input  logic [ui_data_width_p-1:0]    data_i,
  input  logic                          end_i,
  output logic [burst_data_width_p-1:0] line_o,
  output logic                          last_o,
  output logic                          end_err_o
);

  localparam int num_beats_lp = burst_data_width_p / ui_data_width_p;
  localparam int cnt_width_lp = (num_beats_lp > 1) ? $clog2(num_beats_lp) : 1;

  logic [cnt_width_lp-1:0]       cnt_q, cnt_d;
  logic [burst_data_width_p-1:0] line_q, line_d;
  logic                          is_last_slot;
  logic                          take;

  assign is_last_slot = (cnt_q == cnt_width_lp'(num_beats_lp - 1));
  assign take         = active_i & v_i;
  assign last_o       = take & is_last_slot;
  // A mismatched end flag is reported but the beat is still stored, so the
  // line always completes after exactly num_beats_lp beats.
  assign end_err_o    = take & (end_i != is_last_slot);
  assign line_o       = line_q;

  // Slot write and counter advance; there is no backpressure on read data,
  // so every accepted beat is stored in the cycle it arrives.
  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (take) begin
      line_d[cnt_q*ui_data_width_p +: ui_data_width_p] = data_i;
      cnt_d = cnt_q + cnt_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/bsg_dmc_ui_master.sv
// Client-side initiator of the DMC app_* interface. One line-sized request is
// accepted at a time; writes are serialized into app_wdf beats and followed by
// the write command, reads issue the command and deserialize the returned
// beats into a full line presented on a valid/yumi response port.
//   ui_clk_i, ui_clk_sync_rst_n_i : clock, synchronous active-low reset
//   init_calib_complete_i         : controller ready; gates new accepts only
//   req_*                         : valid/ready request (write flag, addr, line data, byte mask)
//   app_if                        : app_* bus toward the controller (master side)
//   resp_v_o/resp_data_o/resp_yumi_i : read line response
//   wr_done_o                     : pulse in the cycle the write command is taken
//   error_o                       : sticky protocol error, cleared only by reset
module bsg_dmc_ui_master
  import bsg_dmc_ui_master_pkg::*;
#(
  parameter int ui_addr_width_p    = 28,
  parameter int ui_data_width_p    = 32,
  parameter int burst_data_width_p = 128,
  localparam int num_beats_lp        = burst_data_width_p / ui_data_width_p,
  localparam int ui_mask_width_lp    = ui_data_width_p >> 3,
  localparam int burst_mask_width_lp = burst_data_width_p >> 3
) (
  input  logic                           ui_clk_i,
  input  logic                           ui_clk_sync_rst_n_i,
  input  logic                           init_calib_complete_i,

  input  logic                           req_v_i,
  output logic                           req_ready_o,
  input  logic                           req_write_i,
  input  logic [ui_addr_width_p-1:0]     req_addr_i,
  input  logic [burst_data_width_p-1:0]  req_data_i,
  input  logic [burst_mask_width_lp-1:0] req_mask_i,

  bsg_dmc_ui_master_if.master            app_if,

  output logic                           resp_v_o,
  output logic [burst_data_width_p-1:0]  resp_data_o,
  input  logic                           resp_yumi_i,

  output logic                           wr_done_o,
  output logic                           error_o
);

  localparam int cnt_width_lp = (num_beats_lp > 1) ? $clog2(num_beats_lp) : 1;

  bsg_dmc_ui_master_state_e state_q, state_d;

  logic [ui_addr_width_p-1:0]     addr_q, addr_d;
  logic [burst_data_width_p-1:0]  data_q, data_d;
  logic [burst_mask_width_lp-1:0] mask_q, mask_d;
  logic                           write_q, write_d;
  logic [cnt_width_lp-1:0]        wcnt_q, wcnt_d;
  logic                           error_q, error_d;

  logic accept;
  logic wbeat_last;
  logic rd_clear;
  logic rd_active;
  logic rd_last;
  logic rd_end_err;

  // Accepting during reset would be lost, so ready is also masked by reset.
  assign req_ready_o = (state_q == UI_M_IDLE) & init_calib_complete_i & ui_clk_sync_rst_n_i;
  assign accept      = req_v_i & req_ready_o;
  assign wbeat_last  = (wcnt_q == cnt_width_lp'(num_beats_lp - 1));
  assign rd_active   = (state_q == UI_M_RWAIT);
  // Read counter restarts on accept and again when the read command is taken.
  assign rd_clear    = accept
                     | ((state_q == UI_M_CMD) & ~write_q & app_if.app_rdy_i);
  assign resp_v_o    = (state_q == UI_M_RESP);
  assign error_o     = error_q;

  bsg_dmc_ui_rd_collect #(
    .ui_data_width_p    (ui_data_width_p),
    .burst_data_width_p (burst_data_width_p)
  ) rd_collect (
    .clk_i     (ui_clk_i),
    .reset_n_i (ui_clk_sync_rst_n_i),
    .clear_i   (rd_clear),
    .active_i  (rd_active),
    .v_i       (app_if.app_rd_data_valid_i),
    .data_i    (app_if.app_rd_data_i),
    .end_i     (app_if.app_rd_data_end_i),
    .line_o    (resp_data_o),
    .last_o    (rd_last),
    .end_err_o (rd_end_err)
  );

  // Sequencer next-state and app_* outputs. The app outputs are driven only in
  // the state that owns them, so everything idles at zero otherwise.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    write_d = write_q;
    wcnt_d  = wcnt_q;

    app_if.app_en_o       = 1'b0;
    app_if.app_cmd_o      = APP_CMD_WR;
    app_if.app_addr_o     = '0;
    app_if.app_wdf_wren_o = 1'b0;
    app_if.app_wdf_data_o = '0;
    app_if.app_wdf_mask_o = '0;
    app_if.app_wdf_end_o  = 1'b0;
    wr_done_o             = 1'b0;

    case (state_q)
      UI_M_IDLE: begin
        if (accept) begin
          addr_d  = req_addr_i;
          data_d  = req_data_i;
          mask_d  = req_mask_i;
          write_d = req_write_i;
          wcnt_d  = '0;
          state_d = req_write_i ? UI_M_WDATA : UI_M_CMD;
        end
      end
      UI_M_WDATA: begin
        app_if.app_wdf_wren_o = 1'b1;
        app_if.app_wdf_data_o = data_q[wcnt_q*ui_data_width_p +: ui_data_width_p];
        app_if.app_wdf_mask_o = mask_q[wcnt_q*ui_mask_width_lp +: ui_mask_width_lp];
        app_if.app_wdf_end_o  = wbeat_last;
        if (app_if.app_wdf_rdy_i) begin
          wcnt_d = wcnt_q + cnt_width_lp'(1);
          if (wbeat_last) begin
            state_d = UI_M_CMD;
          end
        end
      end
      UI_M_CMD: begin
        app_if.app_en_o   = 1'b1;
        app_if.app_cmd_o  = write_q ? APP_CMD_WR : APP_CMD_RD;
        app_if.app_addr_o = addr_q;
        if (app_if.app_rdy_i) begin
          if (write_q) begin
            wr_done_o = 1'b1;
            state_d   = UI_M_IDLE;
          end else begin
            state_d   = UI_M_RWAIT;
          end
        end
      end
      UI_M_RWAIT: begin
        if (rd_last) begin
          state_d = UI_M_RESP;
        end
      end
      UI_M_RESP: begin
        if (resp_yumi_i) begin
          state_d = UI_M_IDLE;
        end
      end
      default: begin
        state_d = UI_M_IDLE;
      end
    endcase

    // Sticky error: bad end flag, a read beat nobody is waiting for (it is
    // dropped), or a yumi with no response on offer.
    error_d = error_q
            | rd_end_err
            | (app_if.app_rd_data_valid_i & ~rd_active)
            | (resp_yumi_i & ~resp_v_o);
  end

  // State and request registers; reset abandons any transaction in flight.
  always_ff @(posedge ui_clk_i) begin
    if (!ui_clk_sync_rst_n_i) begin
      state_q <= UI_M_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      write_q <= 1'b0;
      wcnt_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      write_q <= write_d;
      wcnt_q  <= wcnt_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_bsg_dmc_ui_master.sv
// Directed self-checking bench for bsg_dmc_ui_master (32-bit beats, 128-bit line).
module tb_bsg_dmc_ui_master;
  import bsg_dmc_ui_master_pkg::*;

  logic          ui_clk;
  logic          rst_n;
  logic          calib;
  logic          req_v;
  logic          req_ready;
  logic          req_write;
  logic [27:0]   req_addr;
  logic [127:0]  req_data;
  logic [15:0]   req_mask;
  logic          resp_v;
  logic [127:0]  resp_data;
  logic          resp_yumi;
  logic          wr_done;
  logic          error;

  int checks = 0;
  int passes = 0;

  bsg_dmc_ui_master_if #(.ui_addr_width_p(28), .ui_data_width_p(32)) app_if ();

  bsg_dmc_ui_master #(
    .ui_addr_width_p    (28),
    .ui_data_width_p    (32),
    .burst_data_width_p (128)
  ) dut (
    .ui_clk_i              (ui_clk),
    .ui_clk_sync_rst_n_i   (rst_n),
    .init_calib_complete_i (calib),
    .req_v_i               (req_v),
    .req_ready_o           (req_ready),
    .req_write_i           (req_write),
    .req_addr_i            (req_addr),
    .req_data_i            (req_data),
    .req_mask_i            (req_mask),
    .app_if                (app_if),
    .resp_v_o              (resp_v),
    .resp_data_o           (resp_data),
    .resp_yumi_i           (resp_yumi),
    .wr_done_o             (wr_done),
    .error_o               (error)
  );

  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  // Advance one clock; inputs are changed just after the edge.
  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  // Present one read beat for a single cycle.
  task automatic send_beat(input logic [31:0] d, input logic e);
    app_if.app_rd_data_valid_i = 1'b1;
    app_if.app_rd_data_i       = d;
    app_if.app_rd_data_end_i   = e;
    tick();
    app_if.app_rd_data_valid_i = 1'b0;
    app_if.app_rd_data_end_i   = 1'b0;
  endtask

  // Accept a read and push it through CMD into RWAIT.
  task automatic start_read(input logic [27:0] a);
    req_v = 1'b1; req_write = 1'b0; req_addr = a;
    tick();
    req_v = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; calib = 1'b1; req_v = 1'b0; req_write = 1'b0;
    req_addr = '0; req_data = '0; req_mask = '0; resp_yumi = 1'b0;
    app_if.app_rdy_i = 1'b1; app_if.app_wdf_rdy_i = 1'b1;
    app_if.app_rd_data_valid_i = 1'b0; app_if.app_rd_data_i = '0; app_if.app_rd_data_end_i = 1'b0;
    tick(); tick();
    @(negedge ui_clk);
    checks++; if (req_ready !== 1'b0) $display("[TB] FAIL reset_req_ready got %b exp 0", req_ready); else passes++;
    checks++; if (app_if.app_en_o !== 1'b0 || app_if.app_wdf_wren_o !== 1'b0 || app_if.app_wdf_end_o !== 1'b0)
      $display("[TB] FAIL reset_app_outs got en=%b wren=%b end=%b exp 0", app_if.app_en_o, app_if.app_wdf_wren_o, app_if.app_wdf_end_o); else passes++;
    checks++; if (resp_v !== 1'b0 || wr_done !== 1'b0 || error !== 1'b0)
      $display("[TB] FAIL reset_status got resp_v=%b wr_done=%b err=%b exp 0", resp_v, wr_done, error); else passes++;
    rst_n = 1'b1;
    tick();
    @(negedge ui_clk);
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL idle_req_ready got %b exp 1", req_ready); else passes++;
  endtask

  task automatic test_write_basic();
    logic [31:0] exp_beat [4];
    exp_beat[0] = 32'h22221111; exp_beat[1] = 32'h44443333;
    exp_beat[2] = 32'h66665555; exp_beat[3] = 32'h88887777;
    tick();
    req_v = 1'b1; req_write = 1'b1; req_addr = 28'h100;
    req_data = 128'h88887777_66665555_44443333_22221111; req_mask = 16'h0000;
    @(negedge ui_clk);
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL wr_accept_ready got %b exp 1", req_ready); else passes++;
    tick();
    req_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ui_clk);
      checks++;
      if (app_if.app_wdf_wren_o !== 1'b1 || app_if.app_wdf_data_o !== exp_beat[i] ||
          app_if.app_wdf_mask_o !== 4'h0 || app_if.app_wdf_end_o !== (i == 3) || app_if.app_en_o !== 1'b0)
        $display("[TB] FAIL wr_beat%0d got wren=%b data=%h mask=%h end=%b en=%b exp wren=1 data=%h mask=0 end=%b en=0",
                 i, app_if.app_wdf_wren_o, app_if.app_wdf_data_o, app_if.app_wdf_mask_o,
                 app_if.app_wdf_end_o, app_if.app_en_o, exp_beat[i], (i == 3));
      else passes++;
      tick();
    end
    @(negedge ui_clk);
    checks++;
    if (app_if.app_en_o !== 1'b1 || app_if.app_cmd_o !== APP_CMD_WR || app_if.app_addr_o !== 28'h100 ||
        wr_done !== 1'b1 || app_if.app_wdf_wren_o !== 1'b0)
      $display("[TB] FAIL wr_cmd got en=%b cmd=%h addr=%h done=%b wren=%b exp en=1 cmd=0 addr=100 done=1 wren=0",
               app_if.app_en_o, app_if.app_cmd_o, app_if.app_addr_o, wr_done, app_if.app_wdf_wren_o);
    else passes++;
    tick();
    @(negedge ui_clk);
    checks++; if (app_if.app_en_o !== 1'b0 || wr_done !== 1'b0 || req_ready !== 1'b1)
      $display("[TB] FAIL wr_after got en=%b done=%b ready=%b exp 0 0 1", app_if.app_en_o, wr_done, req_ready); else passes++;
  endtask

  task automatic test_write_stall();
    logic [31:0] exp_beat [4];
    logic [3:0]  exp_mask [4];
    int          wren_cycles;
    exp_beat[0] = 32'hAAAAAAAA; exp_beat[1] = 32'hBBBBBBBB;
    exp_beat[2] = 32'hCCCCCCCC; exp_beat[3] = 32'hDDDDDDDD;
    exp_mask[0] = 4'h3; exp_mask[1] = 4'hC; exp_mask[2] = 4'h5; exp_mask[3] = 4'hA;
    wren_cycles = 0;
    req_v = 1'b1; req_write = 1'b1; req_addr = 28'h340;
    req_data = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA; req_mask = 16'hA5C3;
    tick();
    req_v = 1'b0;
    // Beat index seen on each WDATA cycle: 0, 1 stalled x3, 1, 2, 3.
    for (int c = 0; c < 7; c++) begin
      int bi;
      bi = (c == 0) ? 0 : (c <= 4) ? 1 : c - 3;
      app_if.app_wdf_rdy_i = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
      @(negedge ui_clk);
      if (app_if.app_wdf_wren_o === 1'b1) wren_cycles++;
      checks++;
      if (app_if.app_wdf_data_o !== exp_beat[bi] || app_if.app_wdf_mask_o !== exp_mask[bi] ||
          app_if.app_wdf_end_o !== (bi == 3))
        $display("[TB] FAIL stall_beat c%0d got data=%h mask=%h end=%b exp data=%h mask=%h end=%b",
                 c, app_if.app_wdf_data_o, app_if.app_wdf_mask_o, app_if.app_wdf_end_o,
                 exp_beat[bi], exp_mask[bi], (bi == 3));
      else passes++;
      tick();
    end
    checks++; if (wren_cycles !== 7) $display("[TB] FAIL stall_wren_cycles got %0d exp 7", wren_cycles); else passes++;
    app_if.app_rdy_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge ui_clk);
      checks++;
      if (app_if.app_en_o !== 1'b1 || app_if.app_addr_o !== 28'h340 || wr_done !== 1'b0 || app_if.app_wdf_wren_o !== 1'b0)
        $display("[TB] FAIL stall_cmd_hold c%0d got en=%b addr=%h done=%b wren=%b exp en=1 addr=340 done=0 wren=0",
                 c, app_if.app_en_o, app_if.app_addr_o, wr_done, app_if.app_wdf_wren_o);
      else passes++;
      tick();
    end
    app_if.app_rdy_i = 1'b1;
    @(negedge ui_clk);
    checks++; if (app_if.app_en_o !== 1'b1 || wr_done !== 1'b1)
      $display("[TB] FAIL stall_cmd_take got en=%b done=%b exp 1 1", app_if.app_en_o, wr_done); else passes++;
    tick();
  endtask

  task automatic test_read();
    logic [31:0] a [4];
    logic        pat [8];
    int          idx;
    a[0] = 32'h0BADF00D; a[1] = 32'hCAFEBABE; a[2] = 32'h12345678; a[3] = 32'h9ABCDEF0;
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    idx = 0;
    req_v = 1'b1; req_write = 1'b0; req_addr = 28'h200;
    tick();
    req_v = 1'b0;
    @(negedge ui_clk);
    checks++;
    if (app_if.app_en_o !== 1'b1 || app_if.app_cmd_o !== APP_CMD_RD || app_if.app_addr_o !== 28'h200 || wr_done !== 1'b0)
      $display("[TB] FAIL rd_cmd got en=%b cmd=%h addr=%h done=%b exp en=1 cmd=1 addr=200 done=0",
               app_if.app_en_o, app_if.app_cmd_o, app_if.app_addr_o, wr_done);
    else passes++;
    tick();
    for (int k = 0; k < 8; k++) begin
      app_if.app_rd_data_valid_i = pat[k];
      if (pat[k]) begin
        app_if.app_rd_data_i     = a[idx];
        app_if.app_rd_data_end_i = (idx == 3);
        idx++;
      end
      @(negedge ui_clk);
      checks++; if (resp_v !== 1'b0) $display("[TB] FAIL rd_early_resp k%0d got %b exp 0", k, resp_v); else passes++;
      tick();
      app_if.app_rd_data_valid_i = 1'b0;
      app_if.app_rd_data_end_i   = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge ui_clk);
      checks++;
      if (resp_v !== 1'b1 || resp_data !== 128'h9ABCDEF0_12345678_CAFEBABE_0BADF00D || error !== 1'b0 || req_ready !== 1'b0)
        $display("[TB] FAIL rd_resp c%0d got v=%b data=%h err=%b ready=%b exp v=1 data=9abcdef012345678cafebabe0badf00d err=0 ready=0",
                 c, resp_v, resp_data, error, req_ready);
      else passes++;
      tick();
    end
    resp_yumi = 1'b1;
    @(negedge ui_clk);
    checks++; if (resp_v !== 1'b1 || req_ready !== 1'b0)
      $display("[TB] FAIL rd_yumi_cycle got v=%b ready=%b exp 1 0", resp_v, req_ready); else passes++;
    tick();
    resp_yumi = 1'b0;
    @(negedge ui_clk);
    checks++; if (resp_v !== 1'b0 || req_ready !== 1'b1 || error !== 1'b0)
      $display("[TB] FAIL rd_after got v=%b ready=%b err=%b exp 0 1 0", resp_v, req_ready, error); else passes++;
  endtask

  task automatic test_read_bad_end();
    start_read(28'h240);
    send_beat(32'h00000001, 1'b0);
    send_beat(32'h00000002, 1'b0);
    send_beat(32'h00000003, 1'b1);
    @(negedge ui_clk);
    checks++; if (error !== 1'b1 || resp_v !== 1'b0)
      $display("[TB] FAIL bad_end_flag got err=%b v=%b exp 1 0", error, resp_v); else passes++;
    send_beat(32'h00000004, 1'b0);
    @(negedge ui_clk);
    checks++; if (resp_v !== 1'b1 || resp_data !== 128'h00000004_00000003_00000002_00000001)
      $display("[TB] FAIL bad_end_resp got v=%b data=%h exp v=1 data=00000004000000030000000200000001", resp_v, resp_data); else passes++;
    resp_yumi = 1'b1;
    tick();
    resp_yumi = 1'b0;
    @(negedge ui_clk);
    checks++; if (error !== 1'b1 || req_ready !== 1'b1)
      $display("[TB] FAIL bad_end_sticky got err=%b ready=%b exp 1 1", error, req_ready); else passes++;
  endtask

  task automatic test_calib();
    calib = 1'b0;
    req_v = 1'b1; req_write = 1'b0; req_addr = 28'h280;
    for (int c = 0; c < 2; c++) begin
      @(negedge ui_clk);
      checks++; if (req_ready !== 1'b0 || app_if.app_en_o !== 1'b0 || app_if.app_wdf_wren_o !== 1'b0)
        $display("[TB] FAIL calib_block c%0d got ready=%b en=%b wren=%b exp 0 0 0",
                 c, req_ready, app_if.app_en_o, app_if.app_wdf_wren_o); else passes++;
      tick();
    end
    calib = 1'b1;
    @(negedge ui_clk);
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL calib_ready got %b exp 1", req_ready); else passes++;
    tick();
    req_v = 1'b0;
    @(negedge ui_clk);
    checks++; if (app_if.app_en_o !== 1'b1 || app_if.app_cmd_o !== APP_CMD_RD || app_if.app_addr_o !== 28'h280)
      $display("[TB] FAIL calib_cmd got en=%b cmd=%h addr=%h exp 1 1 280",
               app_if.app_en_o, app_if.app_cmd_o, app_if.app_addr_o); else passes++;
    tick();
    send_beat(32'h11110000, 1'b0);
    send_beat(32'h22220000, 1'b0);
    send_beat(32'h33330000, 1'b0);
    send_beat(32'h44440000, 1'b1);
    @(negedge ui_clk);
    checks++; if (resp_v !== 1'b1 || resp_data !== 128'h44440000_33330000_22220000_11110000)
      $display("[TB] FAIL calib_resp got v=%b data=%h exp v=1 data=44440000333300002222000011110000", resp_v, resp_data); else passes++;
    resp_yumi = 1'b1;
    tick();
    resp_yumi = 1'b0;
  endtask

  task automatic test_reset_midread();
    start_read(28'h300);
    send_beat(32'hDEAD0000, 1'b0);
    send_beat(32'hDEAD0001, 1'b0);
    rst_n = 1'b0;
    tick();
    @(negedge ui_clk);
    checks++;
    if (req_ready !== 1'b0 || app_if.app_en_o !== 1'b0 || app_if.app_wdf_wren_o !== 1'b0 ||
        app_if.app_wdf_end_o !== 1'b0 || resp_v !== 1'b0 || wr_done !== 1'b0 || error !== 1'b0)
      $display("[TB] FAIL midread_reset got ready=%b en=%b wren=%b end=%b v=%b done=%b err=%b exp all 0",
               req_ready, app_if.app_en_o, app_if.app_wdf_wren_o, app_if.app_wdf_end_o, resp_v, wr_done, error);
    else passes++;
    rst_n = 1'b1;
    tick();
    @(negedge ui_clk);
    checks++; if (app_if.app_en_o !== 1'b0 || resp_v !== 1'b0 || req_ready !== 1'b1)
      $display("[TB] FAIL midread_idle got en=%b v=%b ready=%b exp 0 0 1", app_if.app_en_o, resp_v, req_ready); else passes++;
    start_read(28'h3C0);
    send_beat(32'h55550000, 1'b0);
    send_beat(32'h66660001, 1'b0);
    send_beat(32'h77770002, 1'b0);
    send_beat(32'h88880003, 1'b1);
    @(negedge ui_clk);
    checks++; if (resp_v !== 1'b1 || error !== 1'b0 || resp_data !== 128'h88880003_77770002_66660001_55550000)
      $display("[TB] FAIL midread_new got v=%b err=%b data=%h exp v=1 err=0 data=88880003777700026666000155550000",
               resp_v, error, resp_data); else passes++;
    resp_yumi = 1'b1;
    tick();
    resp_yumi = 1'b0;
  endtask

  task automatic test_stray();
    resp_yumi = 1'b1;
    tick();
    resp_yumi = 1'b0;
    @(negedge ui_clk);
    checks++; if (error !== 1'b1) $display("[TB] FAIL stray_yumi got err=%b exp 1", error); else passes++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge ui_clk);
    checks++; if (error !== 1'b0) $display("[TB] FAIL stray_reset_clear got err=%b exp 0", error); else passes++;
    send_beat(32'hFFFF0000, 1'b0);
    @(negedge ui_clk);
    checks++; if (error !== 1'b1 || resp_v !== 1'b0)
      $display("[TB] FAIL stray_beat got err=%b v=%b exp 1 0", error, resp_v); else passes++;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_write_basic();
    test_write_stall();
    test_read();
    test_read_bad_end();
    test_calib();
    test_reset_midread();
    test_stray();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
